// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch stage.
//   ADDR_W   : RAM byte-address / PC width
//   DATA_W   : RAM byte width
//   INSTR_W  : instruction width (two RAM bytes)
//   RESET_PC : PC loaded on reset (must be even)
package fetch_pkg;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned INSTR_W  = 2 * DATA_W;
    localparam int unsigned RESET_PC = 0;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_HI,
        ST_REQ_LO,
        ST_LATCH,
        ST_VALID
    } state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads two consecutive bytes from the program RAM
// read port, assembles a big-endian 16-bit instruction and hands it to decode
// over a valid/ready handshake. Holds the PC and supports branch redirect.
//   clk, rst          : clock, synchronous active-high reset
//   fetch_en          : permit starting new fetches
//   redirect_valid/addr: branch redirect strobe and target (bit 0 ignored)
//   ram_en, ram_rd    : RAM enable / read request (identical)
//   ram_rd_addr       : RAM read address (0 when not reading)
//   ram_rd_data       : RAM read data, one cycle after the request
//   instr_valid/ready : handshake to decode
//   instr_data/pc     : instruction {byte[pc], byte[pc+1]} and its address
module instr_fetch #(
    parameter int unsigned ADDR_W   = fetch_pkg::ADDR_W,
    parameter int unsigned DATA_W   = fetch_pkg::DATA_W,
    parameter int unsigned RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_addr,
    output logic                  ram_en,
    output logic                  ram_rd,
    output logic [ADDR_W-1:0]     ram_rd_addr,
    input  logic [DATA_W-1:0]     ram_rd_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [2*DATA_W-1:0]   instr_data,
    output logic [ADDR_W-1:0]     instr_pc
);

    import fetch_pkg::*;

    localparam int unsigned IW = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] EVEN_MASK = ~ADDR_W'(1);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   pc, pc_d;
    logic [DATA_W-1:0]   hi_byte, hi_byte_d;
    logic                instr_valid_d;
    logic [IW-1:0]       instr_data_d;
    logic [ADDR_W-1:0]   instr_pc_d;

    // State, PC and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= ADDR_W'(RESET_PC);
            hi_byte     <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            hi_byte     <= hi_byte_d;
            instr_valid <= instr_valid_d;
            instr_data  <= instr_data_d;
            instr_pc    <= instr_pc_d;
        end
    end

    // Next-state, datapath updates and RAM read-port decode
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        hi_byte_d     = hi_byte;
        instr_valid_d = instr_valid;
        instr_data_d  = instr_data;
        instr_pc_d    = instr_pc;
        ram_rd        = 1'b0;
        ram_rd_addr   = '0;

        case (state)
            ST_IDLE: begin
                if (fetch_en) state_d = ST_REQ_HI;
            end
            ST_REQ_HI: begin
                ram_rd      = 1'b1;
                ram_rd_addr = pc;
                state_d     = ST_REQ_LO;
            end
            ST_REQ_LO: begin
                // ram_rd_data now carries byte[pc] from the REQ_HI read
                ram_rd      = 1'b1;
                ram_rd_addr = pc + ADDR_W'(1);
                hi_byte_d   = ram_rd_data;
                state_d     = ST_LATCH;
            end
            ST_LATCH: begin
                instr_data_d  = {hi_byte, ram_rd_data};
                instr_pc_d    = pc;
                instr_valid_d = 1'b1;
                state_d       = ST_VALID;
            end
            ST_VALID: begin
                if (instr_valid && instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_d          = pc + ADDR_W'(2);
                    state_d       = fetch_en ? ST_REQ_HI : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect wins over everything, including a same-cycle handshake
        if (redirect_valid) begin
            pc_d          = redirect_addr & EVEN_MASK;
            instr_valid_d = 1'b0;
            state_d       = fetch_en ? ST_REQ_HI : ST_IDLE;
        end
    end

    assign ram_en = ram_rd;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle table for the basic fetch and
// backpressure flow, directed sequences for redirect / fetch_en / reset /
// wrap, and a randomized run against a transaction-level PC model.
module tb_instr_fetch;

    import fetch_pkg::*;

    localparam int unsigned AW = ADDR_W;
    localparam int unsigned DW = DATA_W;
    localparam int unsigned IW = INSTR_W;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          fetch_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          ram_en;
    logic          ram_rd;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_pc;

    // Second instance with RESET_PC=62 for the wrap-around case
    logic          w_fe;
    logic          w_rdy;
    logic          w_redir;
    logic [AW-1:0] w_redir_addr;
    logic          w_ram_en;
    logic          w_ram_rd;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_rdata;
    logic          w_valid;
    logic [IW-1:0] w_data;
    logic [AW-1:0] w_pc;

    logic [DW-1:0] mem [DEPTH];

    instr_fetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .ram_en         (ram_en),
        .ram_rd         (ram_rd),
        .ram_rd_addr    (ram_rd_addr),
        .ram_rd_data    (ram_rd_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    instr_fetch #(.RESET_PC(62)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (w_fe),
        .redirect_valid (w_redir),
        .redirect_addr  (w_redir_addr),
        .ram_en         (w_ram_en),
        .ram_rd         (w_ram_rd),
        .ram_rd_addr    (w_addr),
        .ram_rd_data    (w_rdata),
        .instr_valid    (w_valid),
        .instr_ready    (w_rdy),
        .instr_data     (w_data),
        .instr_pc       (w_pc)
    );

    // Registered-read RAM model, one read port per instance
    always @(posedge clk) begin
        if (ram_en && ram_rd)     ram_rd_data <= mem[ram_rd_addr];
        if (w_ram_en && w_ram_rd) w_rdata     <= mem[w_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        b = a + AW'(1);
        return {mem[a], mem[b]};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Wait (bounded) until the selected instance shows instr_valid
    task automatic wait_valid(input bit wrap_inst, input int max, output int k);
        k = 0;
        for (int i = 0; i < max; i++) begin
            cyc();
            k++;
            if ((wrap_inst ? w_valid : instr_valid) === 1'b1) break;
        end
    endtask

    typedef struct {
        logic          fe;
        logic          rdy;
        logic          exp_rd;
        logic [AW-1:0] exp_addr;
        logic          exp_v;
        logic [IW-1:0] exp_data;
        logic [AW-1:0] exp_pc;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic fe, input logic rdy, input logic rd, input int addr,
                        input logic v, input logic [IW-1:0] d, input int pc);
        vec_t r;
        r.fe = fe; r.rdy = rdy; r.exp_rd = rd; r.exp_addr = AW'(addr);
        r.exp_v = v; r.exp_data = d; r.exp_pc = AW'(pc);
        vt.push_back(r);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int acc;
        logic [AW-1:0] m_pc;
        logic [AW-1:0] rnd_addr;
        logic r_rst, r_fe, r_rdy, r_redir;

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i * 7 + 3);
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
        mem[4] = 8'hE5; mem[5] = 8'hF6; mem[20] = 8'h5A; mem[21] = 8'hA5;

        rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        w_fe = 1'b0; w_rdy = 1'b0; w_redir = 1'b0; w_redir_addr = '0;

        repeat (3) cyc();
        chk("reset instr_valid", 32'(instr_valid), 0);
        chk("reset instr_data",  32'(instr_data), 0);
        chk("reset instr_pc",    32'(instr_pc), 0);
        chk("reset ram_rd",      32'(ram_rd), 0);
        chk("reset ram_en",      32'(ram_en), 0);
        chk("reset ram_rd_addr", 32'(ram_rd_addr), 0);
        rst = 1'b0;

        // Reset-then-fetch, 4-cycle throughput, 10-cycle backpressure, fetch_en drop
        addv(1, 1, 0, 0, 0, 0, 0);
        addv(1, 1, 1, 0, 0, 0, 0);
        addv(1, 1, 1, 1, 0, 0, 0);
        addv(1, 1, 0, 0, 0, 0, 0);
        addv(1, 1, 0, 0, 1, 16'hA1B2, 0);
        addv(1, 1, 1, 2, 0, 0, 0);
        addv(1, 1, 1, 3, 0, 0, 0);
        addv(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) addv(1, 0, 0, 0, 1, 16'hC3D4, 2);
        addv(1, 1, 0, 0, 1, 16'hC3D4, 2);
        addv(1, 1, 1, 4, 0, 0, 0);
        addv(1, 1, 1, 5, 0, 0, 0);
        addv(1, 1, 0, 0, 0, 0, 0);
        addv(0, 1, 0, 0, 1, 16'hE5F6, 4);
        addv(0, 1, 0, 0, 0, 0, 0);
        addv(0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            cyc();
            fetch_en    = vt[i].fe;
            instr_ready = vt[i].rdy;
            chk($sformatf("vec%0d ram_rd", i),      32'(ram_rd), 32'(vt[i].exp_rd));
            chk($sformatf("vec%0d ram_en", i),      32'(ram_en), 32'(vt[i].exp_rd));
            chk($sformatf("vec%0d ram_rd_addr", i), 32'(ram_rd_addr), 32'(vt[i].exp_addr));
            chk($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vt[i].exp_v));
            if (vt[i].exp_v) begin
                chk($sformatf("vec%0d instr_data", i), 32'(instr_data), 32'(vt[i].exp_data));
                chk($sformatf("vec%0d instr_pc", i),   32'(instr_pc), 32'(vt[i].exp_pc));
            end
        end

        // Redirect during REQ_LO (DUT is idle with pc=6)
        fetch_en = 1'b1; instr_ready = 1'b0;
        cyc();
        chk("redir1 req_hi addr", 32'(ram_rd_addr), 6);
        cyc();
        chk("redir1 req_lo addr", 32'(ram_rd_addr), 7);
        redirect_valid = 1'b1; redirect_addr = AW'(6'h15);
        cyc();
        redirect_valid = 1'b0;
        chk("redir1 new req_hi rd", 32'(ram_rd), 1);
        chk("redir1 new req_hi addr", 32'(ram_rd_addr), 32'h14);
        chk("redir1 valid dropped", 32'(instr_valid), 0);
        wait_valid(1'b0, 8, k);
        chk("redir1 valid latency", 32'(k), 3);
        chk("redir1 instr_pc", 32'(instr_pc), 32'h14);
        chk("redir1 instr_data", 32'(instr_data), 32'(word_at(AW'(6'h14))));

        // Redirect coincident with handshake: transfer void, refetch from target
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = AW'(8);
        cyc();
        redirect_valid = 1'b0; instr_ready = 1'b0;
        chk("redir2 valid dropped", 32'(instr_valid), 0);
        chk("redir2 req_hi addr", 32'(ram_rd_addr), 8);
        wait_valid(1'b0, 8, k);
        chk("redir2 valid latency", 32'(k), 3);
        chk("redir2 instr_pc", 32'(instr_pc), 8);
        chk("redir2 instr_data", 32'(instr_data), 32'(word_at(AW'(8))));

        // fetch_en dropped during REQ_HI: instruction completes, then idle
        instr_ready = 1'b1;
        cyc();
        chk("fedrop req_hi addr", 32'(ram_rd_addr), 10);
        fetch_en = 1'b0; instr_ready = 1'b0;
        wait_valid(1'b0, 8, k);
        chk("fedrop valid latency", 32'(k), 3);
        chk("fedrop instr_pc", 32'(instr_pc), 10);
        chk("fedrop instr_data", 32'(instr_data), 32'(word_at(AW'(10))));
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fedrop idle%0d ram_rd", i), 32'(ram_rd), 0);
            chk($sformatf("fedrop idle%0d valid", i), 32'(instr_valid), 0);
            cyc();
        end
        fetch_en = 1'b1;
        cyc();
        chk("fedrop resume rd", 32'(ram_rd), 1);
        chk("fedrop resume addr", 32'(ram_rd_addr), 12);

        // Reset in LATCH
        cyc();
        chk("rstmid req_lo addr", 32'(ram_rd_addr), 13);
        cyc();
        chk("rstmid latch rd", 32'(ram_rd), 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstmid valid", 32'(instr_valid), 0);
        chk("rstmid idle rd", 32'(ram_rd), 0);
        cyc();
        chk("rstmid restart rd", 32'(ram_rd), 1);
        chk("rstmid restart addr", 32'(ram_rd_addr), 0);
        fetch_en = 1'b0;

        // Wrap-around on the RESET_PC=62 instance
        mem[62] = 8'h11; mem[63] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0; w_fe = 1'b1; w_rdy = 1'b1;
        wait_valid(1'b1, 10, k);
        chk("wrap first valid", 32'(w_valid), 1);
        chk("wrap first data", 32'(w_data), 32'h1122);
        chk("wrap first pc", 32'(w_pc), 62);
        wait_valid(1'b1, 10, k);
        chk("wrap spacing", 32'(k), 4);
        chk("wrap second data", 32'(w_data), 32'h3344);
        chk("wrap second pc", 32'(w_pc), 0);
        w_fe = 1'b0; w_rdy = 1'b0;

        // Randomized run against a transaction-level PC model
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'($urandom);
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        m_pc = AW'(RESET_PC);
        acc = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            chk("rnd ram_en", 32'(ram_en), 32'(ram_rd));
            if (ram_rd) chk("rnd rd word addr", 32'(ram_rd_addr >> 1), 32'(m_pc >> 1));
            else        chk("rnd idle addr", 32'(ram_rd_addr), 0);
            if (instr_valid) begin
                chk("rnd instr_pc", 32'(instr_pc), 32'(m_pc));
                chk("rnd instr_data", 32'(instr_data), 32'(word_at(m_pc)));
            end
            r_rst    = ($urandom_range(0, 299) == 0);
            r_fe     = ($urandom_range(0, 7) != 0);
            r_rdy    = ($urandom_range(0, 2) != 0);
            r_redir  = ($urandom_range(0, 31) == 0);
            rnd_addr = AW'($urandom);
            rst = r_rst; fetch_en = r_fe; instr_ready = r_rdy;
            redirect_valid = r_redir; redirect_addr = rnd_addr;
            if (r_rst)
                m_pc = AW'(RESET_PC);
            else if (r_redir)
                m_pc = {rnd_addr[AW-1:1], 1'b0};
            else if (instr_valid && r_rdy) begin
                m_pc = m_pc + AW'(2);
                acc++;
            end
        end
        rst = 1'b0; redirect_valid = 1'b0;
        chk("rnd progress", 32'(acc >= 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly downstream of the 64×8 dual-port program/data RAM. It drives the RAM read port, assembles two consecutive bytes into a 16-bit instruction, and presents it to decode with a valid/ready handshake. It holds the program counter, supports branch redirect, and never touches the RAM write port, which belongs to the loader.

## Interface
- ADDR_W, 6, RAM byte-address width and PC width
- DATA_W, 8, RAM byte width; instruction width is 2*DATA_W
- RESET_PC, 0, PC value loaded on reset (even)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  permit starting new fetches
- redirect_valid  in  1  branch/jump redirect strobe
- redirect_addr  in  ADDR_W  redirect target; bit 0 ignored (forced 0)
- ram_en  out  1  RAM enable; equals ram_rd
- ram_rd  out  1  RAM read request
- ram_rd_addr  out  ADDR_W  RAM read address
- ram_rd_data  in  DATA_W  RAM read data, registered by RAM (valid the cycle after ram_rd)
- instr_valid  out  1  instruction available
- instr_ready  in  1  decode accepts instruction
- instr_data  out  2*DATA_W  {byte[pc], byte[pc+1]}, big-endian
- instr_pc  out  ADDR_W  byte address of instr_data

## Operation
- States: IDLE, REQ_HI, REQ_LO, LATCH, VALID.
- IDLE: ram_rd=0. fetch_en=1 → REQ_HI.
- REQ_HI: ram_rd=1, ram_rd_addr=pc → REQ_LO.
- REQ_LO: ram_rd=1, ram_rd_addr=pc+1; hi_byte <= ram_rd_data → LATCH.
- LATCH: ram_rd=0; instr_data <= {hi_byte, ram_rd_data}, instr_pc <= pc, instr_valid <= 1 → VALID.
- VALID: instr_valid=1, instr_data/instr_pc stable. On instr_valid && instr_ready: instr_valid <= 0, pc <= pc+2, then → REQ_HI if fetch_en else IDLE. Without ready, hold indefinitely.
- fetch_en is sampled only in IDLE and on acceptance in VALID. Deassertion mid-fetch lets the current instruction complete.
- PC arithmetic is modulo 2^ADDR_W. pc is always even, so pc+1 ≤ 63, and pc=62 → pc+2=0.
- Redirect, any state: pc <= {redirect_addr[ADDR_W-1:1],1'b0}, instr_valid <= 0, in-flight bytes discarded, next state REQ_HI if fetch_en else IDLE. Redirect has priority over a same-cycle handshake; that transfer is void. ram_rd stays as the current state dictates in the redirect cycle, and the returned byte is ignored.
- ram_en = ram_rd at all times. No write-port outputs.

## Timing
- Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, hi_byte=0. ram_rd=ram_en=0 and ram_rd_addr=0 combinationally from IDLE.
- First fetch: fetch_en=1 in IDLE at edge N gives REQ_HI in cycle N+1, REQ_LO N+2, LATCH N+3, and instr_valid=1 from N+4.
- Sustained throughput with instr_ready=1 and fetch_en=1: one instruction per 4 cycles (accept in VALID goes to REQ_HI next cycle).
- Redirect at edge M: REQ_HI for the new pc in M+1 if fetch_en; instr_valid=1 earliest at M+4.
- ram_rd_addr is a registered-state decode, glitch-free per cycle; it is don't-care (0) when ram_rd=0.
- rst mid-fetch: abandons all state on that edge, with no partial instruction output.

## Structure
- Package fetch_pkg holds the state enum, ADDR_W/DATA_W defaults, INSTR_W = 2*DATA_W, and the RESET_PC default.
- Single module. There is no natural sub-module; the FSM, PC, and output register stay together.

## Test plan
- Reset then fetch: RAM[0..3]=A1,B2,C3,D4, fetch_en=1, ready=1 → instr_data=16'hA1B2 pc=0 at cycle 4, then 16'hC3D4 pc=2 four cycles later.
- Backpressure: ready=0 for 10 cycles in VALID → instr_valid, instr_data, and instr_pc constant, ram_rd=0. Ready=1 → accepted once, pc advances by 2 only.
- Wrap: RESET_PC=62, RAM[62]=11, RAM[63]=22, RAM[0]=33, RAM[1]=44 → 16'h1122 pc=62, then 16'h3344 pc=0.
- Redirect: redirect to 0x15 during REQ_LO → no instr_valid for the old pc; next output pc=0x14 with {RAM[20],RAM[21]}. Also check redirect coincident with a handshake → the instruction is re-fetched from the new target, not counted.
- fetch_en drop: deassert during REQ_HI → current instruction still delivered, then IDLE with ram_rd=0. Reassert → fetch resumes at pc+2.
- Reset mid-fetch: rst=1 in LATCH → next cycle instr_valid=0, pc=RESET_PC, state IDLE.
